fp16_addsub_sched: RTL and testbench
====================================

// Module: fp16_addsub_sched
// PURPOSE
//  Shares one pipelined FP16 add/sub unit (FPAddSub) between NREQ requesters.
//  - Per cycle: picks at most one requester, issues its operands/op to the unit.
//  - Tracks each issued op through a LATENCY-deep tag pipe.
//  - Routes the unit's result/flags back to the issuing requester.
//  Sits between the DSP-slice operand sources and the FP16 add/sub core.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  LATENCY  4   FPAddSub cycles from operand capture to result valid (>=1)
//  IDW      2   requester id width, $clog2(NREQ)
// PORTS
//  clk         in   1         clock; all logic on rising edge
//  rst         in   1         synchronous, active-low reset
//  hold        in   1         1: no new grants; in-flight ops still complete
//  req_valid   in   NREQ      requester i has an op
//  req_a       in   NREQ*16   operand A, requester i at [16i+15:16i]
//  req_b       in   NREQ*16   operand B, same packing
//  req_op      in   NREQ      0 add, 1 sub
//  req_ready   out  NREQ      one-hot grant, combinational
//  fpu_a       out  16        to FPAddSub a
//  fpu_b       out  16        to FPAddSub b
//  fpu_op      out  1         to FPAddSub operation
//  fpu_result  in   16        from FPAddSub result
//  fpu_flags   in   5         from FPAddSub flags
//  rsp_valid   out  NREQ      one-hot: result for requester i this cycle
//  rsp_id      out  IDW       id of requester owning rsp_data
//  rsp_data    out  16        result, registered
//  rsp_flags   out  5         flags, registered
//  busy        out  1         any op in flight in tag pipe
// BEHAVIOUR
//  - Reset (rst==0 at edge): rr pointer=0; tag pipe valids=0; rsp_valid=0,
//    rsp_id=0, rsp_data=0, rsp_flags=0; busy=0. In-flight ops are discarded:
//    no rsp_valid ever produced for them.
//  - Grant: combinational from req_valid, rr pointer, hold. hold=1 or no
//    valid -> req_ready=0. Transfer = req_valid[i] & req_ready[i].
//  - Round robin: search starts at pointer; after transfer by i,
//    pointer <= (i+1) mod NREQ. No transfer -> pointer unchanged.
//  - Issue: transfer cycle drives fpu_a/b/op from the winner; idle cycles
//    drive 0/0/0. Tag pipe stage0 <= {transfer, winner id}.
//  - Tag pipe shifts every cycle (unit never stalls). Stage LATENCY-1 valid ->
//    next edge registers rsp_valid[id]=1, rsp_id, rsp_data=fpu_result,
//    rsp_flags=fpu_flags. Issue-to-rsp_valid = LATENCY+1 cycles.
//  - Responses have no backpressure; requester must accept on rsp_valid.
//  - Throughput: one op/cycle back-to-back; order preserved (FIFO by issue).
//  - busy = OR of tag-pipe valids; hold=1 and busy=0 => unit quiescent.
//  - req_valid dropped without transfer: legal, nothing issued.
//  - hold asserted mid-burst: stops at that cycle; pointer kept.
// CONFIGURATION
//  FP16_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins;
//    pointer unused (tied 0). Undefined: round robin as above.
// STRUCTURE
//  - Package fp16_sched_pkg: FP16_W=16, FLAGS_W=5, tag typedef {valid,id}.
//  - Sub-module fp16_sched_tagpipe: LATENCY-stage {valid,id} shift register,
//    sync active-low clear, exposes tail and busy.
// TESTING (LATENCY=4, NREQ=4, FPAddSub instantiated)
//  1 Single: req0 a=3C00 b=4000 op=0 -> req_ready[0] same cycle; 5 cycles
//    later rsp_valid=0001, rsp_data=4200.
//  2 All four valid every cycle, ops add 3C00+3C00 -> grants 0,1,2,3,0...
//    one per cycle; rsp_data=4000, rsp_id in same order.
//  3 req2 3C00-3C00 op=1 and req3 4200+BC00 same cycle, ptr=0 -> req2 first
//    (0000), req3 next cycle (4000).
//  4 hold=1 with req_valid=1111 -> req_ready=0, fpu_a=0; busy falls after
//    in-flight rsps drain.
//  5 Issue 3 ops, rst=0 for 1 cycle before rsp -> no rsp_valid; ptr=0.
//  6 FP16_SCHED_FIXED_PRIO_EN, req0 & req1 held valid -> req1 never granted.

Source files
------------

// File: rtl/fp16_sched_pkg.sv
// Shared widths and the in-flight tag type for the FP16 add/sub scheduler.
package fp16_sched_pkg;

  localparam int unsigned FP16_W   = 16;
  localparam int unsigned FLAGS_W  = 5;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp16_sched_tagpipe.sv
// Latency-deep {valid,id} shift register mirroring the FP16 unit's pipeline;
// exposes the tail tag and whether anything is in flight.
module fp16_sched_tagpipe
  import fp16_sched_pkg::*;
#(
  parameter int unsigned Latency = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output tag_t tail_o,
  output logic busy_o
);

  tag_t [Latency-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_i;
    for (int unsigned s = 1; s < Latency; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int unsigned s = 0; s < Latency; s++) begin
      busy_o = busy_o | pipe_q[s].valid;
    end
  end

  assign tail_o = pipe_q[Latency-1];

endmodule

// File: rtl/fp16_addsub_sched.sv
// Shares one pipelined FP16 add/sub unit between NREQ requesters and routes results back.
// Define FP16_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round robin.
module fp16_addsub_sched
  import fp16_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*FP16_W-1:0] req_a,
  input  logic [NREQ*FP16_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_op,
  output logic [NREQ-1:0]        req_ready,
  output logic [FP16_W-1:0]      fpu_a,
  output logic [FP16_W-1:0]      fpu_b,
  output logic                   fpu_op,
  input  logic [FP16_W-1:0]      fpu_result,
  input  logic [FLAGS_W-1:0]     fpu_flags,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [FP16_W-1:0]      rsp_data,
  output logic [FLAGS_W-1:0]     rsp_flags,
  output logic                   busy
);

  logic [IDW-1:0]     win_id;
  logic               transfer;
  tag_t               tag_in, tail;
  logic               tail_ok;
  logic [IDW-1:0]     tail_id;
  logic [NREQ-1:0]    rsp_valid_d, rsp_valid_q;
  logic [IDW-1:0]     rsp_id_d, rsp_id_q;
  logic [FP16_W-1:0]  rsp_data_d, rsp_data_q;
  logic [FLAGS_W-1:0] rsp_flags_d, rsp_flags_q;

`ifndef FP16_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] idx;
`endif

  // Grant: a winner exists only if some requester is valid and hold is low.
  always_comb begin
    transfer = 1'b0;
    win_id   = '0;
`ifdef FP16_SCHED_FIXED_PRIO_EN
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        transfer = 1'b1;
        win_id   = IDW'(i);
      end
    end
`else
    idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr_q) + k) % NREQ);
      if (!transfer && req_valid[idx]) begin
        transfer = 1'b1;
        win_id   = idx;
      end
    end
`endif
    if (hold) begin
      transfer = 1'b0;
    end
    req_ready = '0;
    if (transfer) begin
      req_ready[win_id] = 1'b1;
    end
  end

  always_comb begin
    fpu_a  = '0;
    fpu_b  = '0;
    fpu_op = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (transfer && (win_id == IDW'(i))) begin
        fpu_a  = req_a[i*FP16_W +: FP16_W];
        fpu_b  = req_b[i*FP16_W +: FP16_W];
        fpu_op = req_op[i];
      end
    end
  end

`ifndef FP16_SCHED_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = IDW'((32'(win_id) + 32'd1) % NREQ);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign tag_in.valid = transfer;
  assign tag_in.id    = TAG_ID_W'(win_id);

  fp16_sched_tagpipe #(
    .Latency(LATENCY)
  ) u_tagpipe (
    .clk_i (clk),
    .rst_ni(rst),
    .tag_i (tag_in),
    .tail_o(tail),
    .busy_o(busy)
  );

  // Out-of-range ids cannot be issued; the guard keeps the decode well-defined.
  assign tail_ok = tail.valid && (32'(tail.id) < NREQ);
  assign tail_id = IDW'(tail.id);

  always_comb begin
    rsp_valid_d = '0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    if (tail_ok) begin
      rsp_valid_d[tail_id] = 1'b1;
      rsp_id_d             = tail_id;
      rsp_data_d           = fpu_result;
      rsp_flags_d          = fpu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_fp16_addsub_sched.sv
// Bench for fp16_addsub_sched: behavioural FP16 unit stand-in, cycle model with
// a per-cycle compare, plus directed scenarios with literal expectations.
module tb_fp16_addsub_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 4;
  localparam int unsigned IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 hold = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*16-1:0]   req_a = '0;
  logic [NREQ*16-1:0]   req_b = '0;
  logic [NREQ-1:0]      req_op = '0;
  logic [NREQ-1:0]      req_ready;
  logic [15:0]          fpu_a, fpu_b, fpu_result, rsp_data;
  logic                 fpu_op, busy;
  logic [4:0]           fpu_flags, rsp_flags;
  logic [NREQ-1:0]      rsp_valid;
  logic [IDW-1:0]       rsp_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp16_addsub_sched #(
    .NREQ   (NREQ),
    .LATENCY(LAT),
    .IDW    (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_ready (req_ready),
    .fpu_a     (fpu_a),
    .fpu_b     (fpu_b),
    .fpu_op    (fpu_op),
    .fpu_result(fpu_result),
    .fpu_flags (fpu_flags),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FP16 arithmetic on exactly representable normal values via reals.
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(int'(h[9:0])) / 1024.0;
    for (int i = 0; i < e - 15; i++) m = m * 2.0;
    for (int i = 0; i < 15 - e; i++) m = m / 2.0;
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    logic s;
    int   e, man;
    real  m;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 15;
    for (int i = 0; i < 40 && m >= 2.0; i++) begin m = m / 2.0; e++; end
    for (int i = 0; i < 40 && m < 1.0; i++) begin m = m * 2.0; e--; end
    man = $rtoi((m - 1.0) * 1024.0 + 0.5);
    return {s, 5'(e), 10'(man)};
  endfunction

  function automatic logic [15:0] fp_addsub(input logic [15:0] a, input logic [15:0] b,
                                            input logic op);
    return r2h(op ? (h2r(a) - h2r(b)) : (h2r(a) + h2r(b)));
  endfunction

  function automatic logic [4:0] fp_flags(input logic [15:0] r);
    return {r == 16'h0, r[15], r[12:10]};
  endfunction

  // Stand-in FP16 unit: LAT register stages from operand capture to result.
  logic [15:0] fres_q [LAT];
  always @(posedge clk) begin
    fres_q[0] <= fp_addsub(fpu_a, fpu_b, fpu_op);
    for (int i = 1; i < int'(LAT); i++) fres_q[i] <= fres_q[i-1];
  end
  assign fpu_result = fres_q[LAT-1];
  assign fpu_flags  = fp_flags(fpu_result);

  // Cycle model: expected responses keyed by the cycle they must appear.
  int          cyc = 0;
  bit          armed = 1'b0;
  int          ptr_m = 0;
  bit          exp_v [64];
  int          exp_id [64];
  logic [15:0] exp_d [64];

  always @(negedge clk) begin
    int g, slot;
    bit bsy;
    g = -1;
    if (!hold) begin
`ifdef FP16_SCHED_FIXED_PRIO_EN
      for (int i = 0; i < int'(NREQ); i++) if (g < 0 && req_valid[i]) g = i;
`else
      for (int k = 0; k < int'(NREQ); k++)
        if (g < 0 && req_valid[(ptr_m + k) % int'(NREQ)]) g = (ptr_m + k) % int'(NREQ);
`endif
    end
    slot = cyc % 64;
    if (armed) begin
      chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("fpu_a", 32'(fpu_a), (g < 0) ? 32'd0 : 32'(req_a[g*16 +: 16]));
      chk("fpu_b", 32'(fpu_b), (g < 0) ? 32'd0 : 32'(req_b[g*16 +: 16]));
      chk("fpu_op", 32'(fpu_op), (g < 0) ? 32'd0 : 32'(req_op[g]));
      chk("rsp_valid", 32'(rsp_valid), exp_v[slot] ? (32'd1 << exp_id[slot]) : 32'd0);
      if (exp_v[slot]) begin
        chk("rsp_id", 32'(rsp_id), 32'(exp_id[slot]));
        chk("rsp_data", 32'(rsp_data), 32'(exp_d[slot]));
        chk("rsp_flags", 32'(rsp_flags), 32'(fp_flags(exp_d[slot])));
      end
      bsy = 1'b0;
      for (int d = 1; d <= int'(LAT); d++) if (exp_v[(cyc + d) % 64]) bsy = 1'b1;
      chk("busy", 32'(busy), 32'(bsy));
    end
    exp_v[slot] = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 64; i++) exp_v[i] = 1'b0;
      ptr_m = 0;
      armed = 1'b1;
    end else if (g >= 0) begin
      exp_v[(cyc + int'(LAT) + 1) % 64]  = 1'b1;
      exp_id[(cyc + int'(LAT) + 1) % 64] = g;
      exp_d[(cyc + int'(LAT) + 1) % 64]  = fp_addsub(req_a[g*16 +: 16], req_b[g*16 +: 16], req_op[g]);
`ifndef FP16_SCHED_FIXED_PRIO_EN
      ptr_m = (g + 1) % int'(NREQ);
`endif
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic op);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_op[i]         = op;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (busy || rsp_valid != '0); i++) step();
    @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pin the FP16 stand-in against hand-computed values.
    chk("pin_add_1_2", 32'(fp_addsub(16'h3C00, 16'h4000, 1'b0)), 32'h4200);
    chk("pin_add_1_1", 32'(fp_addsub(16'h3C00, 16'h3C00, 1'b0)), 32'h4000);
    chk("pin_sub_1_1", 32'(fp_addsub(16'h3C00, 16'h3C00, 1'b1)), 32'h0000);
    chk("pin_add_3_m1", 32'(fp_addsub(16'h4200, 16'hBC00, 1'b0)), 32'h4000);
    chk("pin_add_4_1", 32'(fp_addsub(16'h4400, 16'h3C00, 1'b0)), 32'h4500);

    rst = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Single request: grant same cycle, response LAT+1 cycles later.
    set_req(0, 16'h3C00, 16'h4000, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (3) step();
    @(negedge clk);
    chk("t1_early", 32'(rsp_valid), 32'h0);
    step();
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_data", 32'(rsp_data), 32'h4200);
    drain();

    // All four valid every cycle.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 16'h3C00, 16'h3C00, 1'b0);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifndef FP16_SCHED_FIXED_PRIO_EN
      chk("t2_grant", 32'(req_ready), 32'd1 << (i % 4));
      if (i >= 5) chk("t2_rsp_id", 32'(rsp_id), 32'(i - 5));
`endif
      if (i >= 5) chk("t2_rsp_data", 32'(rsp_data), 32'h4000);
      step();
    end
    req_valid = '0;
    drain();

    // req2 and req3 together from pointer 0.
    do_reset();
    set_req(2, 16'h3C00, 16'h3C00, 1'b1);
    set_req(3, 16'h4200, 16'hBC00, 1'b0);
    req_valid = 4'b1100;
    @(negedge clk);
    chk("t3_first", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("t3_second", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    repeat (3) step();
    @(negedge clk);
    chk("t3_rsp2_valid", 32'(rsp_valid), 32'h4);
    chk("t3_rsp2_data", 32'(rsp_data), 32'h0000);
    step();
    @(negedge clk);
    chk("t3_rsp3_valid", 32'(rsp_valid), 32'h8);
    chk("t3_rsp3_id", 32'(rsp_id), 32'h3);
    chk("t3_rsp3_data", 32'(rsp_data), 32'h4000);
    drain();

    // hold mid-burst: no grants, in-flight ops drain, pointer kept.
    set_req(0, 16'h3C00, 16'h3C00, 1'b0);
    set_req(1, 16'h4000, 16'h3C00, 1'b0);
    set_req(2, 16'h4400, 16'h3C00, 1'b0);
    set_req(3, 16'h4800, 16'h3C00, 1'b0);
    req_valid = 4'b1111;
    step();
    step();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_ready", 32'(req_ready), 32'h0);
      chk("t4_fpu_a", 32'(fpu_a), 32'h0);
      if (i == 0) chk("t4_busy_inflight", 32'(busy), 32'h1);
      step();
    end
    @(negedge clk);
    chk("t4_busy_drained", 32'(busy), 32'h0);
    step();
    hold = 1'b0;
    @(negedge clk);
`ifndef FP16_SCHED_FIXED_PRIO_EN
    chk("t4_resume", 32'(req_ready), 32'h4);
    chk("t4_resume_a", 32'(fpu_a), 32'h4400);
`endif
    step();
    req_valid = '0;
    drain();

    // Reset while ops are in flight: they are discarded.
    req_valid = 4'b1111;
    repeat (3) step();
    req_valid = '0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(rsp_valid), 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      step();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    chk("t5_ptr0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    drain();

`ifdef FP16_SCHED_FIXED_PRIO_EN
    req_valid = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_fixed", 32'(req_ready), 32'h1);
      step();
    end
    req_valid = '0;
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
